// File: rtl/regfile_rdport_pipe_if.sv
// Bus bundle for regfile_rdport_pipe: write port, per-port read request/address
// and registered read data, valid strobes and written-register count.
interface regfile_rdport_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic [NUM_RD-1:0]          rd_valid;
  logic [ADDR_W:0]            busy_cnt;

  modport master (
    output we, waddr, wdata, rd_en, raddr,
    input  rdata, rd_valid, busy_cnt
  );

  modport slave (
    input  we, waddr, wdata, rd_en, raddr,
    output rdata, rd_valid, busy_cnt
  );
endinterface

// File: rtl/regfile_rdport_pipe.sv
// Multi-port register file with registered one-cycle-latency read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to matching reads.
module regfile_rdport_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_rdport_pipe_if.slave   rf
);

  localparam int unsigned NREG  = 32'(1) << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]        mem_q [NREG];
  logic [NREG-1:0]          written_q;
  logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;

  logic                     wr_ok;
  logic                     first_wr;
  logic [DATA_W-1:0]        rd_sel [NUM_RD];
  logic [DATA_W-1:0]        rd_val [NUM_RD];

  // Writes to register 0 are discarded when it is hardwired to zero
  assign wr_ok    = rf.we && !((ZERO_REG != 0) && (rf.waddr == '0));
  assign first_wr = wr_ok && !written_q[rf.waddr];

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (first_wr && (busy_cnt_q != CNT_W'(NREG))) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end
  end

  // Storage array and first-write tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      written_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[rf.waddr]     <= rf.wdata;
        written_q[rf.waddr] <= 1'b1;
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Per-port binary select tree: level l halves the candidates using address bit l-1
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] ra;
    assign ra = rf.raddr[p*ADDR_W +: ADDR_W];

    for (genvar l = 0; l <= ADDR_W; l++) begin : g_lvl
      localparam int unsigned LW = NREG >> l;
      logic [DATA_W-1:0] v [LW];
      if (l == 0) begin : g_leaf
        for (genvar k = 0; k < LW; k++) begin : g_k
          assign v[k] = mem_q[k];
        end
      end else begin : g_mux
        for (genvar k = 0; k < LW; k++) begin : g_k
          assign v[k] = ra[l-1] ? g_lvl[l-1].v[2*k+1] : g_lvl[l-1].v[2*k];
        end
      end
    end

    assign rd_sel[p] = g_lvl[ADDR_W].v[0];
  end

  // Value presented to each read register: tree output, optional forward, zero override
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_val[p] = rd_sel[p];
`ifdef REGFILE_BYPASS_EN
      if (rf.we && (rf.waddr == rf.raddr[p*ADDR_W +: ADDR_W])) begin
        rd_val[p] = rf.wdata;
      end
`endif
      if ((ZERO_REG != 0) && (rf.raddr[p*ADDR_W +: ADDR_W] == '0)) begin
        rd_val[p] = '0;
      end
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    rd_valid_d = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rf.rd_en[p]) begin
        rdata_d[p*DATA_W +: DATA_W] = rd_val[p];
        rd_valid_d[p]               = 1'b1;
      end
    end
  end

  // Read data registers; an idle port holds its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rf.rdata    = rdata_q;
  assign rf.rd_valid = rd_valid_q;
  assign rf.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_rdport_pipe.sv
// Bench for regfile_rdport_pipe: three configurations driven in lockstep and
// compared against an array-based reference model.
module tb_regfile_rdport_pipe;

  localparam int unsigned ND = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  rd_en;
  logic [4:0]  ra [4];

  regfile_rdport_pipe_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_a ();
  regfile_rdport_pipe_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) if_b ();
  regfile_rdport_pipe_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) if_c ();

  regfile_rdport_pipe #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_n), .rf(if_a));
  regfile_rdport_pipe #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .rf(if_b));
  regfile_rdport_pipe #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0))
    dut_c (.clk(clk), .rst_n(rst_n), .rf(if_c));

  assign if_a.we    = we;
  assign if_a.waddr = waddr;
  assign if_a.wdata = wdata;
  assign if_a.rd_en = rd_en[1:0];
  assign if_a.raddr = {ra[1], ra[0]};

  assign if_b.we    = we;
  assign if_b.waddr = waddr[2:0];
  assign if_b.wdata = wdata[15:0];
  assign if_b.rd_en = rd_en;
  assign if_b.raddr = {ra[3][2:0], ra[2][2:0], ra[1][2:0], ra[0][2:0]};

  assign if_c.we    = we;
  assign if_c.waddr = waddr[2:0];
  assign if_c.wdata = wdata[15:0];
  assign if_c.rd_en = rd_en;
  assign if_c.raddr = {ra[3][2:0], ra[2][2:0], ra[1][2:0], ra[0][2:0]};

  logic [127:0] obs_rdata [ND];
  logic [3:0]   obs_vld   [ND];
  logic [5:0]   obs_cnt   [ND];

  assign obs_rdata[0] = 128'(if_a.rdata);
  assign obs_rdata[1] = 128'(if_b.rdata);
  assign obs_rdata[2] = 128'(if_c.rdata);
  assign obs_vld[0]   = 4'(if_a.rd_valid);
  assign obs_vld[1]   = 4'(if_b.rd_valid);
  assign obs_vld[2]   = 4'(if_c.rd_valid);
  assign obs_cnt[0]   = 6'(if_a.busy_cnt);
  assign obs_cnt[1]   = 6'(if_b.busy_cnt);
  assign obs_cnt[2]   = 6'(if_c.busy_cnt);

  int unsigned dw  [ND] = '{32, 16, 16};
  int unsigned aw  [ND] = '{5, 3, 3};
  int unsigned nrd [ND] = '{2, 4, 4};
  bit          zr  [ND] = '{1'b1, 1'b1, 1'b0};

  logic [31:0] m_mem [ND][32];
  bit          m_wr  [ND][32];
  int unsigned m_cnt [ND];
  logic [31:0] m_rd  [ND][4];
  bit          m_vld [ND][4];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] dmask(input int d);
    return 32'hFFFF_FFFF >> (32 - dw[d]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[d][i] = '0;
        m_wr[d][i]  = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        m_rd[d][p]  = '0;
        m_vld[d][p] = 1'b0;
      end
    end
  endtask

  // One rising edge of every configuration, from the current bench inputs
  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      int unsigned amask = (1 << aw[d]) - 1;
      int unsigned wa    = int'(waddr) & amask;
      logic [31:0] wd    = wdata & dmask(d);
      for (int p = 0; p < nrd[d]; p++) begin
        int unsigned a = int'(ra[p]) & amask;
        if (rd_en[p]) begin
          if (zr[d] && a == 0)                 m_rd[d][p] = '0;
          else if (BYP && we && wa == a)       m_rd[d][p] = wd;
          else                                 m_rd[d][p] = m_mem[d][a];
          m_vld[d][p] = 1'b1;
        end else begin
          m_vld[d][p] = 1'b0;
        end
      end
      if (we && !(zr[d] && wa == 0)) begin
        m_mem[d][wa] = wd;
        if (!m_wr[d][wa]) begin
          m_wr[d][wa] = 1'b1;
          if (m_cnt[d] < (1 << aw[d])) m_cnt[d]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < nrd[d]; p++) begin
        chk($sformatf("%s/d%0d/rdata%0d", tag, d, p),
            64'((obs_rdata[d] >> (p * dw[d])) & 128'(dmask(d))), 64'(m_rd[d][p]));
        chk($sformatf("%s/d%0d/rd_valid%0d", tag, d, p),
            64'(obs_vld[d][p]), 64'(m_vld[d][p]));
      end
      chk($sformatf("%s/d%0d/busy_cnt", tag, d), 64'(obs_cnt[d]), 64'(m_cnt[d]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    we    = 1'b0;
    rd_en = '0;
  endtask

  // Reset asserted mid-cycle must clear outputs before any clock edge
  task automatic async_reset(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, "/cnt_zero"}, 64'(obs_cnt[0]), 64'd0);
    tick({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    we = 1'b0; waddr = '0; wdata = '0; rd_en = '0;
    for (int p = 0; p < 4; p++) ra[p] = '0;
    model_reset();

    #2 rst_n = 1'b0;
    #10;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reads right after reset return zero
    rd_en = 4'hF; ra[0] = 5'd0; ra[1] = 5'd9; ra[2] = 5'd17; ra[3] = 5'd31;
    tick("rd_after_rst");
    chk("rd_after_rst/a1", 64'(obs_rdata[0][63:32]), 64'd0);

    // Basic write then read
    idle(); we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    tick("wr7");
    idle(); rd_en = 4'b0001; ra[0] = 5'd7;
    tick("rd7");
    chk("rd7/data", 64'(obs_rdata[0][31:0]), 64'hDEAD_BEEF);
    chk("rd7/valid", 64'(obs_vld[0][0]), 64'd1);
    chk("rd7/cnt", 64'(obs_cnt[0]), 64'd1);
    idle();
    tick("rd7_strobe_end");
    chk("rd7/valid_drop", 64'(obs_vld[0][0]), 64'd0);

    // Two ports, distinct addresses, then hold
    we = 1'b1; waddr = 5'd3; wdata = 32'h1111_1111;
    tick("wr3");
    waddr = 5'd30; wdata = 32'h2222_2222;
    tick("wr30");
    idle(); rd_en = 4'b0011; ra[0] = 5'd3; ra[1] = 5'd30;
    tick("rd_dual");
    chk("rd_dual/data", 64'(obs_rdata[0][63:0]), 64'h2222_2222_1111_1111);
    idle();
    tick("rd_dual_hold");
    chk("rd_dual_hold/data", 64'(obs_rdata[0][63:0]), 64'h2222_2222_1111_1111);
    chk("rd_dual_hold/valid", 64'(obs_vld[0]), 64'd0);

    // Register 0 write is discarded when hardwired
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    tick("wr0");
    idle(); rd_en = 4'b0001; ra[0] = 5'd0;
    tick("rd0");
    chk("rd0/data", 64'(obs_rdata[0][31:0]), 64'd0);
    chk("rd0/cnt", 64'(obs_cnt[0]), 64'd3);

    // Same-edge write/read of one register
    we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5_A5A5; rd_en = '0;
    tick("wr5");
    wdata = 32'h5A5A_5A5A; rd_en = 4'b0001; ra[0] = 5'd5;
    tick("hazard");
    chk("hazard/data", 64'(obs_rdata[0][31:0]), BYP ? 64'h5A5A_5A5A : 64'hA5A5_A5A5);
    idle(); rd_en = 4'b0001; ra[0] = 5'd5;
    tick("hazard_next");
    chk("hazard_next/data", 64'(obs_rdata[0][31:0]), 64'h5A5A_5A5A);

    // Mid-operation reset, then write sweep and saturation
    we = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_0BAD; rd_en = 4'hF;
    async_reset("rst_mid");
    for (int i = 0; i < 8; i++) begin
      idle(); we = 1'b1; waddr = 5'(i); wdata = 32'hC0DE_0000 | 32'(i * 32'h111);
      tick("sweep");
    end
    chk("sweep/cnt_b", 64'(obs_cnt[1]), 64'd7);
    chk("sweep/cnt_c", 64'(obs_cnt[2]), 64'd8);
    waddr = 5'd2; wdata = 32'h0000_2222;
    tick("rewrite2");
    chk("rewrite2/cnt_b", 64'(obs_cnt[1]), 64'd7);
    chk("rewrite2/cnt_c", 64'(obs_cnt[2]), 64'd8);
    for (int i = 0; i < 8; i++) begin
      waddr = 5'(i); wdata = 32'hC0DE_0000 | 32'(i * 32'h111);
      tick("sweep2");
    end
    chk("sat/cnt_c", 64'(obs_cnt[2]), 64'd8);
    idle(); rd_en = 4'hF;
    for (int p = 0; p < 4; p++) ra[p] = 5'(p + 1);
    tick("rd_quad");
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rd_quad/b%0d", p), 64'(obs_rdata[1][p*16 +: 16]), 64'((p + 1) * 32'h111));
    end

    // Randomised traffic with collisions encouraged and one more async reset
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wdata = $urandom;
      rd_en = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        ra[p] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      end
      if (n == 200) async_reset("rst_rand");
      else tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
